// File: rtl/imem_fetch_stage.sv
// Instruction-fetch front end: drives the imem read port, tracks the fetch PC,
// handles stall/redirect and presents {inst, inst_pc, inst_valid} to decode.
module imem_fetch_stage #(
   parameter int              XLEN                = 32,
   parameter int              INST_MEM_ADDR_WIDTH = 14,
   parameter logic [XLEN-1:0] RESET_PC            = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST            = 32'h0000_0013
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           stall,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   output logic [INST_MEM_ADDR_WIDTH-1:0] imem_adrb,
   output logic                           imem_en,
   input  logic [XLEN-1:0]                imem_doutb,
   output logic [XLEN-1:0]                inst,
   output logic [XLEN-1:0]                inst_pc,
   output logic                           inst_valid,
   output logic                           misaligned_err,
   output logic [31:0]                    fetch_count
);

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   state_t            state_reg;
   state_t            state_next;
   logic [XLEN-1:0]   pc_reg;
   logic [XLEN-1:0]   pc_next;
   logic              valid_reg;
   logic              misaligned_reg;
   logic              misaligned_next;
   logic [31:0]       fetch_count_reg;
   logic [31:0]       fetch_count_next;
   logic              fetch_en;
   logic              inst_valid_c;

   // pc_reg is the byte PC of the word currently presented on imem_doutb.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_BOOT;
         pc_reg          <= RESET_PC;
         valid_reg       <= 1'b0;
         misaligned_reg  <= 1'b0;
         fetch_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         misaligned_reg  <= misaligned_next;
         fetch_count_reg <= fetch_count_next;
         if (fetch_en) begin
            pc_reg    <= pc_next;
            valid_reg <= 1'b1;
         end
      end
   end

   // Redirect beats everything, including the boot fetch and a stall.
   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg + PC_STEP;
      fetch_en         = 1'b0;
      inst_valid_c     = 1'b0;
      misaligned_next  = misaligned_reg;
      fetch_count_next = fetch_count_reg;

      if (redirect_valid) begin
         pc_next = redirect_pc;
      end else if (state_reg == S_BOOT) begin
         pc_next = RESET_PC;
      end else if (stall) begin
         pc_next = pc_reg;
      end

      fetch_en = reset & ((state_reg == S_BOOT) | redirect_valid | !stall);
      if (fetch_en) begin
         state_next = S_RUN;
      end

      inst_valid_c = valid_reg & !redirect_valid & (state_reg == S_RUN);

      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         misaligned_next = 1'b1;
      end

      if (inst_valid_c && !stall) begin
         fetch_count_next = fetch_count_reg + 32'd1;
      end
   end

   // Low two bits are dropped, so a misaligned target fetches its enclosing word.
   assign imem_adrb      = pc_next[INST_MEM_ADDR_WIDTH+1:2];
   assign imem_en        = fetch_en;
   assign inst_valid     = inst_valid_c;
   assign inst           = inst_valid_c ? imem_doutb : NOP_INST;
   assign inst_pc        = pc_reg;
   assign misaligned_err = misaligned_reg;
   assign fetch_count    = fetch_count_reg;

endmodule

// File: tb/tb_imem_fetch_stage.sv
// Directed self-checking bench for imem_fetch_stage with a 1-cycle-latency imem model.
module tb_imem_fetch_stage;

   localparam int AW = 14;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] W0  = 32'h0050_0093;
   localparam logic [31:0] W1  = 32'h00A0_0113;
   localparam logic [31:0] W2  = 32'h0020_81B3;

   logic          clk;
   logic          reset;
   logic          stall;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic [AW-1:0] imem_adrb;
   logic          imem_en;
   logic [31:0]   imem_doutb;
   logic [31:0]   inst;
   logic [31:0]   inst_pc;
   logic          inst_valid;
   logic          misaligned_err;
   logic [31:0]   fetch_count;

   logic [31:0]   mem [0:(1<<AW)-1];
   int            n_cmp;
   int            n_mis;

   imem_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_adrb      (imem_adrb),
      .imem_en        (imem_en),
      .imem_doutb     (imem_doutb),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_valid     (inst_valid),
      .misaligned_err (misaligned_err),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_en) imem_doutb <= mem[imem_adrb];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // Drive one cycle's inputs just after the edge, then let outputs settle.
   task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic vld);
      check_val({tag, ".inst_pc"}, inst_pc, pc);
      check_val({tag, ".inst"}, inst, ins);
      check_val({tag, ".inst_valid"}, 32'(inst_valid), 32'(vld));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp          = 0;
      n_mis          = 0;
      reset          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_doutb     = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = W0;
      mem[1] = W1;
      mem[2] = W2;

      // Held in reset
      repeat (3) @(posedge clk);
      #2;
      check_val("rst.en", 32'(imem_en), 32'd0);
      check_out("rst", 32'h0, NOP, 1'b0);
      check_val("rst.count", fetch_count, 32'd0);
      check_val("rst.mis", 32'(misaligned_err), 32'd0);

      // 1: boot and straight-line fetch
      @(posedge clk); #1; reset = 1'b1; #1;
      check_val("boot.en", 32'(imem_en), 32'd1);
      check_val("boot.adrb", 32'(imem_adrb), 32'd0);
      check_val("boot.valid", 32'(inst_valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0); check_out("t1.c0", 32'h0, W0, 1'b1);
      cycle(1'b0, 1'b0, 32'h0); check_out("t1.c1", 32'h4, W1, 1'b1);
      cycle(1'b0, 1'b0, 32'h0); check_out("t1.c2", 32'h8, W2, 1'b1);
      cycle(1'b0, 1'b0, 32'h0);
      check_val("t1.pc", inst_pc, 32'hC);
      check_val("t1.count", fetch_count, 32'd3);

      // Restart for the stall scenario
      @(posedge clk); #1; reset = 1'b0; #1;
      check_val("rst2.count", fetch_count, 32'd0);
      @(posedge clk); #1; reset = 1'b1; #1;
      cycle(1'b0, 1'b0, 32'h0); check_out("t2.c0", 32'h0, W0, 1'b1);

      // 2: stall three cycles on 0x4
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 1'b0, 32'h0);
         check_out($sformatf("t2.stall%0d", k), 32'h4, W1, 1'b1);
         check_val($sformatf("t2.stall%0d.en", k), 32'(imem_en), 32'd0);
         check_val($sformatf("t2.stall%0d.count", k), fetch_count, 32'd1);
      end
      cycle(1'b0, 1'b0, 32'h0);
      check_out("t2.rel", 32'h4, W1, 1'b1);
      check_val("t2.rel.adrb", 32'(imem_adrb), 32'd2);

      // 3: redirect to 0x40 while 0x8 is on the bus
      cycle(1'b0, 1'b1, 32'h40);
      check_out("t3.kill", 32'h8, NOP, 1'b0);
      check_val("t3.adrb", 32'(imem_adrb), 32'h10);
      check_val("t3.count", fetch_count, 32'd2);
      cycle(1'b0, 1'b0, 32'h0);
      check_out("t3.tgt", 32'h40, 32'hA000_0010, 1'b1);

      // 4: redirect together with stall
      cycle(1'b1, 1'b1, 32'h80);
      check_val("t4.en", 32'(imem_en), 32'd1);
      check_val("t4.adrb", 32'(imem_adrb), 32'h20);
      check_val("t4.valid", 32'(inst_valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      check_out("t4.tgt", 32'h80, 32'hA000_0020, 1'b1);
      check_val("t4.count", fetch_count, 32'd3);

      // 5: misaligned redirect, then an aligned one
      cycle(1'b0, 1'b1, 32'h42);
      check_val("t5.adrb", 32'(imem_adrb), 32'h10);
      check_val("t5.mis0", 32'(misaligned_err), 32'd0);
      check_val("t5.count", fetch_count, 32'd4);
      cycle(1'b0, 1'b1, 32'h0);
      check_val("t5.mis1", 32'(misaligned_err), 32'd1);
      check_out("t5.kill", 32'h42, NOP, 1'b0);
      cycle(1'b0, 1'b0, 32'h0);
      check_out("t5.tgt", 32'h0, W0, 1'b1);
      check_val("t5.mis2", 32'(misaligned_err), 32'd1);

      for (int k = 1; k <= 8; k++) begin
         cycle(1'b0, 1'b0, 32'h0);
         check_val($sformatf("t5.run%0d.pc", k), inst_pc, 32'(4 * k));
      end
      check_val("t5.run.inst", inst, 32'hA000_0008);
      check_val("t5.run.count", fetch_count, 32'd12);

      // 6: reset mid-stream at 0x20
      @(posedge clk); #1; reset = 1'b0; #1;
      check_out("t6.rst", 32'h0, NOP, 1'b0);
      check_val("t6.en", 32'(imem_en), 32'd0);
      check_val("t6.count", fetch_count, 32'd0);
      check_val("t6.mis", 32'(misaligned_err), 32'd0);
      @(posedge clk); #1; reset = 1'b1; #1;
      check_val("t6.boot.adrb", 32'(imem_adrb), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      check_out("t6.c0", 32'h0, W0, 1'b1);

      // PC and word-address wrap at the top of the address space
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
      check_val("wrap.adrb", 32'(imem_adrb), 32'h3FFF);
      cycle(1'b0, 1'b0, 32'h0);
      check_out("wrap.top", 32'hFFFF_FFFC, 32'hA000_3FFF, 1'b1);
      check_val("wrap.adrb0", 32'(imem_adrb), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      check_out("wrap.zero", 32'h0, W0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
